// File: rtl/fir_interpolator.sv
// Polyphase interpolating FIR: one input sample per handshake and CPS phase outputs on
// consecutive cycles, computed combinationally from the registered delay line and coefficients.
module fir_interpolator #(
    parameter int CPS   = 2,
    parameter int TAP   = 8,
    parameter int SHIFT = 0,
    localparam int L    = TAP / CPS,
    localparam int AW   = (TAP > 1) ? $clog2(TAP) : 1,
    localparam int PW   = (CPS > 1) ? $clog2(CPS) : 1
) (
    input  logic                 clk_data,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [15:0]   in_data,
    input  logic                 coef_we,
    input  logic [AW-1:0]        coef_addr,
    input  logic signed [15:0]   coef_data,
    output logic                 out_valid,
    output logic [PW-1:0]        out_phase,
    output logic signed [15:0]   out_data
);

    localparam int ACC_W = 33 + $clog2(L);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(32768);
    localparam logic [AW:0]   TAP_W    = (AW+1)'(TAP);
    localparam logic [PW-1:0] PH_LAST  = PW'(CPS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    // Handshake: a sample is taken on an edge where in_valid && in_ready; in_ready depends
    // only on FSM state, never on in_valid.
    state_t                  state_q, state_d;
    logic [PW-1:0]           ph_q, ph_d;
    logic signed [15:0]      x_q [L];
    logic signed [15:0]      h_q [TAP];
    logic                    out_valid_q, out_valid_d;
    logic [PW-1:0]           out_phase_q, out_phase_d;
    logic signed [15:0]      out_data_q, out_data_d;

    logic                    accept;
    logic [AW-1:0]           hidx;
    logic signed [31:0]      prod;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] shifted;
    logic signed [15:0]      y_sat;

    assign in_ready = (state_q == IDLE) || (ph_q == PH_LAST);
    assign accept   = in_valid && in_ready;

    always_comb begin
        acc  = '0;
        hidx = '0;
        prod = '0;
        for (int j = 0; j < L; j++) begin
            hidx = AW'(j * CPS) + AW'(ph_q);
            prod = h_q[hidx] * x_q[j];
            acc  = acc + {{(ACC_W-32){prod[31]}}, prod};
        end
        shifted = acc >>> SHIFT;
        if (shifted > SAT_MAX)      y_sat = 16'sh7fff;
        else if (shifted < SAT_MIN) y_sat = 16'sh8000;
        else                        y_sat = shifted[15:0];
    end

    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        out_valid_d = out_valid_q;
        out_phase_d = out_phase_q;
        out_data_d  = out_data_q;
        case (state_q)
            IDLE: begin
                out_valid_d = 1'b0;
                if (accept) begin
                    state_d = RUN;
                    ph_d    = '0;
                end
            end
            RUN: begin
                out_valid_d = 1'b1;
                out_data_d  = y_sat;
                out_phase_d = ph_q;
                if (ph_q != PH_LAST) begin
                    ph_d = ph_q + PW'(1);
                end else if (accept) begin
                    ph_d = '0;
                end else begin
                    state_d = IDLE;
                    ph_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
                ph_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk_data or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ph_q        <= '0;
            out_valid_q <= 1'b0;
            out_phase_q <= '0;
            out_data_q  <= '0;
            for (int j = 0; j < L; j++) x_q[j] <= '0;
            for (int k = 0; k < TAP; k++) h_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            out_valid_q <= out_valid_d;
            out_phase_q <= out_phase_d;
            out_data_q  <= out_data_d;
            // The phase output above still sees the pre-shift delay line on this edge.
            if (accept) begin
                x_q[0] <= in_data;
                for (int j = 1; j < L; j++) x_q[j] <= x_q[j-1];
            end
            if (coef_we && ({1'b0, coef_addr} < TAP_W)) begin
                h_q[coef_addr] <= coef_data;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_phase = out_phase_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_fir_interpolator.sv
// Directed bench for fir_interpolator (CPS=2, TAP=8); a second instance with SHIFT=15
// shares the stimulus and is checked only in the saturation bursts.
module tb_fir_interpolator;

    logic               clk_data = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic signed [15:0] in_data;
    logic               coef_we;
    logic [2:0]         coef_addr;
    logic signed [15:0] coef_data;
    logic               in_ready, in_ready15;
    logic               out_valid, out_valid15;
    logic [0:0]         out_phase, out_phase15;
    logic signed [15:0] out_data, out_data15;

    int n_vec = 0;
    int n_err = 0;

    logic signed [15:0] hs   [8];
    logic signed [15:0] xs   [8];
    logic signed [15:0] ys   [16];
    logic signed [15:0] ys15 [16];
    logic [15:0]        exp_q[$];

    fir_interpolator #(.CPS(2), .TAP(8), .SHIFT(0)) dut (
        .clk_data (clk_data),  .rst_n    (rst_n),
        .in_valid (in_valid),  .in_ready (in_ready),  .in_data (in_data),
        .coef_we  (coef_we),   .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(out_valid), .out_phase(out_phase), .out_data (out_data)
    );

    fir_interpolator #(.CPS(2), .TAP(8), .SHIFT(15)) dut15 (
        .clk_data (clk_data),    .rst_n    (rst_n),
        .in_valid (in_valid),    .in_ready (in_ready15),  .in_data (in_data),
        .coef_we  (coef_we),     .coef_addr(coef_addr),   .coef_data(coef_data),
        .out_valid(out_valid15), .out_phase(out_phase15), .out_data (out_data15)
    );

    always #5 clk_data = ~clk_data;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk_data);
        #1;
    endtask

    task automatic set_coefs();
        for (int k = 0; k < 8; k++) begin
            coef_we   = 1'b1;
            coef_addr = 3'(k);
            coef_data = hs[k];
            step();
        end
        coef_we = 1'b0;
    endtask

    // Sends xs[0..n-1] back-to-back and checks 2n outputs against ys (and ys15 if use15).
    task automatic burst(input int n, input bit use15);
        logic [15:0] e;
        exp_q.delete();
        for (int o = 0; o < 2 * n; o++) exp_q.push_back(ys[o]);
        in_valid = 1'b1;
        in_data  = xs[0];
        chk("idle_ready", in_ready, 1);
        step();
        chk("accept_ovalid", out_valid, 0);
        chk("accept_ready", in_ready, 0);
        for (int o = 0; o < 2 * n; o++) begin
            step();
            e = exp_q.pop_front();
            chk("ovalid", out_valid, 1);
            chk("odata", $signed(out_data), $signed(e));
            chk("ophase", out_phase, o % 2);
            if (use15) chk("odata15", $signed(out_data15), ys15[o]);
            if (o % 2 == 0) begin
                chk("ready_ph1", in_ready, 1);
                if (o / 2 + 1 < n) in_data = xs[o / 2 + 1];
                else               in_valid = 1'b0;
            end else begin
                chk("ready_ph0", in_ready, (o == 2 * n - 1) ? 1 : 0);
            end
        end
        step();
        chk("drop_ovalid", out_valid, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;

        // Reset held with inputs toggling.
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'(i);
            in_data   = 16'(100 * i + 1);
            coef_we   = 1'b1;
            coef_addr = 3'(i);
            coef_data = 16'sh7fff;
            step();
            chk("rst_ovalid", out_valid, 0);
            chk("rst_odata", $signed(out_data), 0);
            chk("rst_ophase", out_phase, 0);
            chk("rst_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        coef_we  = 1'b0;
        rst_n    = 1'b1;
        step();
        chk("post_rst_ovalid", out_valid, 0);
        chk("post_rst_ready", in_ready, 1);

        // Impulse response on a clean delay line.
        for (int k = 0; k < 8; k++) hs[k] = 16'(k + 1);
        set_coefs();
        xs = '{default: 16'sd0};
        ys = '{default: 16'sd0};
        xs[0] = 16'sd1;
        for (int k = 0; k < 8; k++) ys[k] = 16'(k + 1);
        burst(5, 1'b0);

        // Basic phases.
        hs = '{default: 16'sd0};
        hs[0] = 16'sd1;
        hs[1] = 16'sd2;
        set_coefs();
        xs = '{default: 16'sd0};
        ys = '{default: 16'sd0};
        xs[0] = 16'sd5; xs[1] = 16'sd3;
        ys[0] = 16'sd5; ys[1] = 16'sd10; ys[2] = 16'sd3; ys[3] = 16'sd6;
        burst(2, 1'b0);

        // Saturation, both shifts.
        hs = '{default: 16'sd0};
        hs[0] = 16'sh7fff;
        set_coefs();
        ys = '{default: 16'sd0};
        ys15 = '{default: 16'sd0};
        xs[0] = 16'sh7fff; ys[0] = 16'sh7fff; ys15[0] = 16'sd32766;
        burst(1, 1'b1);
        xs[0] = 16'sh8000; ys[0] = 16'sh8000; ys15[0] = -16'sd32767;
        burst(1, 1'b1);

        // Handshake gap between two single samples.
        hs = '{default: 16'sd0};
        hs[0] = 16'sd1;
        hs[1] = 16'sd2;
        set_coefs();
        ys = '{default: 16'sd0};
        xs[0] = 16'sd7; ys[0] = 16'sd7; ys[1] = 16'sd14;
        burst(1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("gap_ovalid", out_valid, 0);
            chk("gap_ready", in_ready, 1);
        end
        xs[0] = 16'sd4; ys[0] = 16'sd4; ys[1] = 16'sd8;
        burst(1, 1'b0);

        // Reset during phase 0 of a burst.
        in_valid = 1'b1;
        in_data  = 16'sd6;
        step();
        in_valid = 1'b0;
        step();
        chk("mid_ovalid", out_valid, 1);
        chk("mid_odata", $signed(out_data), 6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ovalid", out_valid, 0);
        chk("mid_rst_odata", $signed(out_data), 0);
        chk("mid_rst_ophase", out_phase, 0);
        chk("mid_rst_ready", in_ready, 1);
        @(posedge clk_data);
        #1;
        rst_n = 1'b1;
        step();
        chk("after_rst_ovalid", out_valid, 0);
        step();
        chk("after_rst_ovalid2", out_valid, 0);
        ys = '{default: 16'sd0};
        xs[0] = 16'sd9;
        burst(1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
